// File: rtl/pll_ctrl_pkg.sv
// Shared state type, default parameter values and helpers for the PLL lock controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } pll_ctrl_state_t;

    localparam int DEF_RST_PULSE_CYC    = 4;
    localparam int DEF_LOCK_TIMEOUT_CYC = 1000;
    localparam int DEF_STABLE_CYC       = 16;
    localparam int DEF_MAX_RETRIES      = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a stable lock, then releases sys_rst.
// Define PLL_LOCK_CTRL_RELOCK_CNT_EN to build the saturating lock-loss counter on relock_cnt.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = DEF_STABLE_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_cnt
);

    localparam int CNT_MAX_A = (RST_PULSE_CYC > STABLE_CYC) ? RST_PULSE_CYC : STABLE_CYC;
    localparam int CNT_MAX   = (LOCK_TIMEOUT_CYC > CNT_MAX_A) ? LOCK_TIMEOUT_CYC : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

    logic locked_s;

    pll_ctrl_state_t    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == CNT_W'(RST_PULSE_CYC - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock seen on the timeout cycle still wins over the retry.
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    cnt_d   = '0;
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_q == RETRY_W'(MAX_RETRIES - 1)) ? ST_FAIL : ST_PLL_RST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase

        // Outputs follow the next state so they are registered alongside it.
        pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;
    assign fail    = fail_q;

`ifdef PLL_LOCK_CTRL_RELOCK_CNT_EN
    logic [7:0] relock_q, relock_d;

    always_comb begin
        relock_d = relock_q;
        if ((state_q == ST_RUN) && !locked_s) begin
            relock_d = sat_inc8(relock_q);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            relock_q <= 8'd0;
        end else begin
            relock_q <= relock_d;
        end
    end

    assign relock_cnt = relock_q;
`else
    assign relock_cnt = 8'd0;
`endif

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter RST_PULSE_CYC, default 4: pll_rst pulse width in refclk cycles (>=1).
REQ-002 Parameter LOCK_TIMEOUT_CYC, default 1000: cycles allowed in WAIT_LOCK before a retry.
REQ-003 Parameter STABLE_CYC, default 16: consecutive synchronized-locked cycles required before release.
REQ-004 Parameter MAX_RETRIES, default 3: consecutive timeouts before FAIL.
REQ-005 Port: refclk  input  1  single clock (50 MHz reference); all logic SHALL be in this domain.
REQ-006 Port: rst  input  1  asynchronous, active-high reset.
REQ-007 Port: locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-008 Port: pll_rst  output  1  active-high reset driven to the PLL.
REQ-009 Port: sys_rst  output  1  active-high reset for downstream logic clocked by the PLL outputs.
REQ-010 Port: ready  output  1  high while the PLL is locked and stable.
REQ-011 Port: fail  output  1  sticky; lock never achieved within MAX_RETRIES attempts.
REQ-012 Port: relock_cnt  output  8  count of lock losses seen in RUN.

Function
REQ-013 locked SHALL pass through a 2-flop synchronizer; locked_s denotes its output (2-cycle latency).
REQ-014 FSM states SHALL be PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL; all outputs registered.
REQ-015 PLL_RST: pll_rst=1 for exactly RST_PULSE_CYC cycles, then go to WAIT_LOCK with cycle counter cleared.
REQ-016 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE with counter cleared; counter reaching LOCK_TIMEOUT_CYC-1 with locked_s=0 -> retry+1.
REQ-017 On timeout, retry+1 == MAX_RETRIES -> FAIL; otherwise -> PLL_RST.
REQ-018 If locked_s=1 on the timeout cycle, lock SHALL take priority (go to STABLE, no retry increment).
REQ-019 STABLE: locked_s=0 on any cycle -> WAIT_LOCK with fresh timeout; STABLE_CYC consecutive high cycles -> RUN.
REQ-020 RUN: sys_rst=0, ready=1, retry cleared on entry; sys_rst=1 and ready=0 in every other state.
REQ-021 RUN and locked_s=0 -> PLL_RST; relock_cnt +1, saturating at 255 (no wrap).
REQ-022 FAIL: pll_rst=1, sys_rst=1, fail=1; exit only via rst.
REQ-023 Timing from locked rising at input to sys_rst low SHALL be 2 + STABLE_CYC + 1 cycles (±1 for input sampling phase).

Reset
REQ-024 rst SHALL asynchronously force: state PLL_RST, counter 0, retry 0, pll_rst=1, sys_rst=1, ready=0, fail=0, relock_cnt=0, synchronizer flops 0.
REQ-025 rst asserted mid-operation (any state) SHALL immediately assert sys_rst; release restarts at PLL_RST with full pulse.

Configuration
REQ-026 Macro PLL_LOCK_CTRL_RELOCK_CNT_EN defined: relock_cnt counts per REQ-021.
REQ-027 Macro undefined: relock_cnt port present and tied to 0; counter register not synthesized.

Structure
REQ-028 Package pll_ctrl_pkg SHALL hold the state enum typedef (pll_ctrl_state_t) and default parameter constants.
REQ-029 Sub-module sync_2ff SHALL implement the locked synchronizer (async reset to 0).

Verification (RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=100, STABLE_CYC=16, MAX_RETRIES=3)
REQ-030 rst pulse, locked high from cycle 10 -> pll_rst high 4 cycles after release, ready=1 and sys_rst=0 by cycle 10+19+1, relock_cnt=0.
REQ-031 locked held 0 -> three 4-cycle pll_rst pulses separated by 100-cycle waits, then fail=1, pll_rst=1 permanently.
REQ-032 locked glitch high 5 cycles then low -> returns to WAIT_LOCK, ready stays 0, no retry consumed until timeout.
REQ-033 In RUN, drop locked for 3 cycles, 300 times -> each drop re-enters PLL_RST, relock_cnt saturates at 255 (0 if macro undefined).
REQ-034 rst asserted asynchronously in RUN (between refclk edges) -> sys_rst=1, ready=0 before next refclk edge; full sequence repeats.
